// File: rtl/pipe_pkg.sv
// Shared definitions for the EX stage: ALU op codes, forward selects,
// multiply FSM encoding and the EX/MEM control bundle.
package pipe_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_NOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_LUI   = 4'd6;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_MFHI  = 4'd9;
    localparam logic [3:0] ALU_MFLO  = 4'd10;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle, plus the forwarding/flush/stall side band.
interface ex_stage_if #(parameter int DATA_W = 32);
    logic              flush_EX;
    logic [1:0]        forward_A;
    logic [1:0]        forward_B;
    logic [DATA_W-1:0] readData1_IDEX;
    logic [DATA_W-1:0] readData2_IDEX;
    logic [DATA_W-1:0] imm_IDEX;
    logic              ALUSrc_IDEX;
    logic [3:0]        ALUOp_IDEX;
    logic [4:0]        rd_IDEX;
    logic              RegWrite_IDEX;
    logic              MemRead_IDEX;
    logic              MemWrite_IDEX;
    logic              MemToReg_IDEX;
    logic [DATA_W-1:0] writeData_MEMWB;
    logic [DATA_W-1:0] aluResult_EXMEM;
    logic [DATA_W-1:0] writeData_EXMEM;
    logic [4:0]        rd_EXMEM;
    logic              RegWrite_EXMEM;
    logic              MemRead_EXMEM;
    logic              MemWrite_EXMEM;
    logic              MemToReg_EXMEM;
    logic              stall_EX;

    modport master (
        output flush_EX, forward_A, forward_B, readData1_IDEX, readData2_IDEX,
               imm_IDEX, ALUSrc_IDEX, ALUOp_IDEX, rd_IDEX, RegWrite_IDEX,
               MemRead_IDEX, MemWrite_IDEX, MemToReg_IDEX, writeData_MEMWB,
        input  aluResult_EXMEM, writeData_EXMEM, rd_EXMEM, RegWrite_EXMEM,
               MemRead_EXMEM, MemWrite_EXMEM, MemToReg_EXMEM, stall_EX
    );

    modport slave (
        input  flush_EX, forward_A, forward_B, readData1_IDEX, readData2_IDEX,
               imm_IDEX, ALUSrc_IDEX, ALUOp_IDEX, rd_IDEX, RegWrite_IDEX,
               MemRead_IDEX, MemWrite_IDEX, MemToReg_IDEX, writeData_MEMWB,
        output aluResult_EXMEM, writeData_EXMEM, rd_EXMEM, RegWrite_EXMEM,
               MemRead_EXMEM, MemWrite_EXMEM, MemToReg_EXMEM, stall_EX
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The product register starts as {0, B}; its low half shifts out as the high half accumulates.
module mul_seq
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_CYC = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                idle_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                wr_o,
    output logic [2*DATA_W-1:0] product_o
);
    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    mul_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] step;
    logic                last;

    always_comb begin
        sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step = {sum, prod_q[DATA_W-1:1]};
        last = (cnt_q == CW'(MUL_CYC - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        wr_o    = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    mcand_d = a_i;
                    prod_d  = {{DATA_W{1'b0}}, b_i};
                    cnt_d   = '0;
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (abort_i) begin
                    state_d = MUL_IDLE;
                end else begin
                    prod_d = step;
                    cnt_d  = cnt_q + 1'b1;
                    if (last) begin
                        wr_o    = 1'b1;
                        state_d = MUL_DONE;
                    end
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign idle_o    = (state_q == MUL_IDLE);
    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = step;
endmodule

// File: rtl/ex_stage.sv
// MIPS EX stage: operand forwarding, ALU, HI/LO with iterative MULTU, and
// the EX/MEM pipeline register. Stalled and flushed cycles load bubbles.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_CYC = 32
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    logic [DATA_W-1:0]   op_a, op_b_fwd, alu_b, alu_res;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   alu_q, wdata_q;
    logic [4:0]          rd_q;
    ctrl_t               ctrl_q, ctrl_in;
    logic                mul_start, mul_idle, mul_busy, mul_done, mul_wr;
    logic [2*DATA_W-1:0] mul_prod;
    logic                stall, bubble;

    always_comb begin
        case (bus.forward_A)
            FWD_EXMEM: op_a = alu_q;
            FWD_MEMWB: op_a = bus.writeData_MEMWB;
            default:   op_a = bus.readData1_IDEX;
        endcase
        case (bus.forward_B)
            FWD_EXMEM: op_b_fwd = alu_q;
            FWD_MEMWB: op_b_fwd = bus.writeData_MEMWB;
            default:   op_b_fwd = bus.readData2_IDEX;
        endcase
        alu_b = bus.ALUSrc_IDEX ? bus.imm_IDEX : op_b_fwd;
    end

    always_comb begin
        alu_res = '0;
        case (bus.ALUOp_IDEX)
            ALU_ADD:  alu_res = op_a + alu_b;
            ALU_SUB:  alu_res = op_a - alu_b;
            ALU_AND:  alu_res = op_a & alu_b;
            ALU_OR:   alu_res = op_a | alu_b;
            ALU_NOR:  alu_res = ~(op_a | alu_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            ALU_LUI:  alu_res = bus.imm_IDEX << 16;
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // Flush outranks a new MULTU, so a killed MULTU never starts or stalls.
    assign mul_start = (bus.ALUOp_IDEX == ALU_MULTU) && !bus.flush_EX;
    assign stall     = mul_busy || (mul_idle && mul_start);
    assign bubble    = bus.flush_EX || stall || mul_done;
    assign ctrl_in   = {bus.RegWrite_IDEX, bus.MemRead_IDEX, bus.MemWrite_IDEX, bus.MemToReg_IDEX};

    mul_seq #(.DATA_W(DATA_W), .MUL_CYC(MUL_CYC)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (bus.flush_EX),
        .a_i       (op_a),
        .b_i       (op_b_fwd),
        .idle_o    (mul_idle),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .wr_o      (mul_wr),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            if (mul_wr) begin
                {hi_q, lo_q} <= mul_prod;
            end
            if (bubble) begin
                alu_q   <= '0;
                wdata_q <= '0;
                rd_q    <= '0;
                ctrl_q  <= '0;
            end else begin
                alu_q   <= alu_res;
                wdata_q <= op_b_fwd;
                rd_q    <= bus.rd_IDEX;
                ctrl_q  <= ctrl_in;
            end
        end
    end

    assign bus.aluResult_EXMEM = alu_q;
    assign bus.writeData_EXMEM = wdata_q;
    assign bus.rd_EXMEM        = rd_q;
    assign bus.RegWrite_EXMEM  = ctrl_q.reg_write;
    assign bus.MemRead_EXMEM   = ctrl_q.mem_read;
    assign bus.MemWrite_EXMEM  = ctrl_q.mem_write;
    assign bus.MemToReg_EXMEM  = ctrl_q.mem_to_reg;
    assign bus.stall_EX        = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and popped after the capturing clock edge.
module tb_ex_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(32)) bus();
    ex_stage #(.DATA_W(32), .MUL_CYC(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [72:0] v;
        logic [72:0] m;
    } exp_t;

    // Layout {alu[72:41], wd[40:9], rd[8:4], RegWrite, MemRead, MemWrite, MemToReg}
    localparam logic [72:0] M_ALL  = {73{1'b1}};
    localparam logic [72:0] M_NORD = ~(73'h1F0);
    localparam logic [72:0] M_CTL  = 73'hE;

    exp_t        sbq[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    function automatic logic [72:0] obs();
        return {bus.aluResult_EXMEM, bus.writeData_EXMEM, bus.rd_EXMEM, bus.RegWrite_EXMEM,
                bus.MemRead_EXMEM, bus.MemWrite_EXMEM, bus.MemToReg_EXMEM};
    endfunction

    function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] rd, input logic [3:0] c, input logic [72:0] m);
        exp_t x;
        x.v = {alu, wd, rd, c};
        x.m = m;
        return x;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic [3:0] c, input logic [1:0] fa, input logic [1:0] fb);
        bus.ALUOp_IDEX     = op;
        bus.readData1_IDEX = a;
        bus.readData2_IDEX = b;
        bus.imm_IDEX       = imm;
        bus.ALUSrc_IDEX    = src;
        bus.rd_IDEX        = rd;
        {bus.RegWrite_IDEX, bus.MemRead_IDEX, bus.MemWrite_IDEX, bus.MemToReg_IDEX} = c;
        bus.forward_A      = fa;
        bus.forward_B      = fb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(ALU_MULTU, 32'd7, 32'd9, 32'd0, 1'b0, 5'd1, 4'b0000, FWD_IDEX, FWD_IDEX);
        step(); step(); step();
        rst_n = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000, FWD_IDEX, FWD_IDEX);
        step(); step();
        total++;
        if (bus.stall_EX !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got=%b want=0", bus.stall_EX);
        end else $display("txn reset_stall ok");
        total++;
        if (obs() !== 73'h0) begin
            bad++;
            $display("FAIL reset_exmem: got=%h want=0", obs());
        end else $display("txn reset_exmem ok");
        rst_n = 1'b1;
        drive(ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 4'b1000, FWD_IDEX, FWD_IDEX);
        sbq.push_back(mk(32'h0, 32'h0, 5'd2, 4'b1000, M_ALL));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL reset_hi: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn reset_hi ok %h", obs());
        drive(ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd3, 4'b1000, FWD_IDEX, FWD_IDEX);
        sbq.push_back(mk(32'h0, 32'h0, 5'd3, 4'b1000, M_ALL));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL reset_lo: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn reset_lo ok %h", obs());
    endtask

    task automatic test_forward();
        logic [1:0]  fa[3];
        logic [31:0] ra[3];
        logic [31:0] ex[3];
        logic [31:0] wd[3];
        fa = '{FWD_IDEX, FWD_EXMEM, 2'b11};
        ra = '{32'd7, 32'd5, 32'd5};
        ex = '{32'd7, 32'd16, 32'd14};
        wd = '{32'd0, 32'd9, 32'd9};
        bus.writeData_MEMWB = 32'd9;
        for (int i = 0; i < 3; i++) begin
            drive(ALU_ADD, ra[i], (i == 0) ? 32'd0 : 32'd100, 32'd0, 1'b0, 5'(i + 1), 4'b1000,
                  fa[i], (i == 0) ? FWD_IDEX : FWD_MEMWB);
            sbq.push_back(mk(ex[i], wd[i], 5'(i + 1), 4'b1000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL forward_%0d: got=%h want=%h", i, obs() & e.m, e.v & e.m);
            end else $display("txn forward_%0d ok %h", i, obs());
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops[7];
        logic [31:0] as[7];
        logic [31:0] bs[7];
        logic [31:0] ims[7];
        logic [31:0] exs[7];
        ops = '{ALU_SUB, ALU_SLT, ALU_SLT, ALU_NOR, ALU_LUI, ALU_AND, ALU_OR};
        as  = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        bs  = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFF00FF00, 32'hFF00FF00};
        ims = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0, 32'h0};
        exs = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h12340000, 32'hF000F000, 32'hFFF0FFF0};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], as[i], bs[i], ims[i], (ops[i] == ALU_LUI), 5'(i + 4), 4'b1000, FWD_IDEX, FWD_IDEX);
            sbq.push_back(mk(exs[i], bs[i], 5'(i + 4), 4'b1000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL alu_op%0d: got=%h want=%h", ops[i], obs() & e.m, e.v & e.m);
            end else $display("txn alu_op%0d ok %h", ops[i], obs());
        end
    endtask

    task automatic test_multu();
        logic [31:0] a = 32'hFFFFFFFF;
        logic [31:0] b = 32'd2;
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        drive(ALU_MULTU, a, b, 32'd0, 1'b0, 5'd7, 4'b1000, FWD_IDEX, FWD_IDEX);
        for (int i = 0; i < 33; i++) begin
            #1;
            total++;
            if (bus.stall_EX !== 1'b1) begin
                bad++;
                $display("FAIL multu_stall cyc%0d: got=%b want=1", i, bus.stall_EX);
            end
            sbq.push_back(mk(32'h0, 32'h0, 5'd0, 4'b0000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL multu_bubble cyc%0d: got=%h want=%h", i, obs() & e.m, e.v & e.m);
            end else $display("txn multu_bubble cyc%0d ok", i);
            if (i == 0) begin
                // Operands were latched; these changes must not reach the product.
                bus.readData1_IDEX  = 32'd3;
                bus.forward_A       = FWD_EXMEM;
                bus.forward_B       = FWD_MEMWB;
                bus.writeData_MEMWB = 32'd77;
            end
        end
        #1;
        total++;
        if (bus.stall_EX !== 1'b0) begin
            bad++;
            $display("FAIL multu_done_stall: got=%b want=0", bus.stall_EX);
        end else $display("txn multu_done_stall ok");
        sbq.push_back(mk(32'h0, 32'h0, 5'd0, 4'b0000, M_CTL));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL multu_retire: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn multu_retire ok");
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? ALU_MFHI : ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd8, 4'b1000, FWD_IDEX, FWD_IDEX);
            sbq.push_back(mk((i == 0) ? exp_hi : exp_lo, 32'h0, 5'd8, 4'b1000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL multu_%s: got=%h want=%h", (i == 0) ? "hi" : "lo", obs() & e.m, e.v & e.m);
            end else $display("txn multu_%s ok %h", (i == 0) ? "hi" : "lo", obs());
        end
    endtask

    task automatic test_flush();
        drive(ALU_MULTU, 32'd3, 32'd5, 32'd0, 1'b0, 5'd9, 4'b1000, FWD_IDEX, FWD_IDEX);
        for (int i = 0; i < 11; i++) begin
            bus.flush_EX = (i == 10);
            sbq.push_back(mk(32'h0, 32'h0, 5'd0, 4'b0000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL flush_mul_bubble cyc%0d: got=%h want=%h", i, obs() & e.m, e.v & e.m);
            end else $display("txn flush_mul_bubble cyc%0d ok", i);
        end
        bus.flush_EX = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd10, 4'b1000, FWD_IDEX, FWD_IDEX);
        #1;
        total++;
        if (bus.stall_EX !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got=%b want=0", bus.stall_EX);
        end else $display("txn flush_stall ok");
        sbq.push_back(mk(32'd3, 32'd2, 5'd10, 4'b1000, M_ALL));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL flush_after_add: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn flush_after_add ok");
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? ALU_MFHI : ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd11, 4'b1000, FWD_IDEX, FWD_IDEX);
            sbq.push_back(mk((i == 0) ? exp_hi : exp_lo, 32'h0, 5'd11, 4'b1000, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL flush_keep_%s: got=%h want=%h", (i == 0) ? "hi" : "lo", obs() & e.m, e.v & e.m);
            end else $display("txn flush_keep_%s ok", (i == 0) ? "hi" : "lo");
        end
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd12, 4'b1000, FWD_IDEX, FWD_IDEX);
        bus.flush_EX = 1'b1;
        sbq.push_back(mk(32'h0, 32'h0, 5'd0, 4'b0000, M_ALL));
        step();
        bus.flush_EX = 1'b0;
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL flush_add: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn flush_add ok");
    endtask

    task automatic test_store();
        drive(ALU_ADD, 32'hAB, 32'd0, 32'd0, 1'b0, 5'd13, 4'b1000, FWD_IDEX, FWD_IDEX);
        sbq.push_back(mk(32'hAB, 32'h0, 5'd13, 4'b1000, M_ALL));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL store_seed: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn store_seed ok");
        drive(ALU_ADD, 32'h100, 32'h55, 32'h8, 1'b1, 5'd0, 4'b0010, FWD_IDEX, FWD_EXMEM);
        sbq.push_back(mk(32'h108, 32'hAB, 5'd0, 4'b0010, M_NORD));
        step();
        e = sbq.pop_front(); total++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL store: got=%h want=%h", obs() & e.m, e.v & e.m);
        end else $display("txn store ok %h", obs());
    endtask

    task automatic test_back_to_back();
        logic [3:0]  opl[6];
        logic [3:0]  op;
        logic [31:0] a, b, mw, av, bv, res;
        logic [31:0] last = 32'h108;
        logic [1:0]  fa, fb;
        opl = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT};
        for (int i = 0; i < 12; i++) begin
            op = opl[$urandom_range(0, 5)];
            a  = $urandom();
            b  = $urandom();
            mw = $urandom();
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            av = (fa == 2'b10) ? last : (fa == 2'b01) ? mw : a;
            bv = (fb == 2'b10) ? last : (fb == 2'b01) ? mw : b;
            res = alu_model(op, av, bv);
            bus.writeData_MEMWB = mw;
            drive(op, a, b, 32'd0, 1'b0, 5'(i + 14), 4'b1001, fa, fb);
            sbq.push_back(mk(res, bv, 5'(i + 14), 4'b1001, M_ALL));
            step();
            e = sbq.pop_front(); total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
                bad++;
                $display("FAIL b2b_%0d op%0d fa%b fb%b: got=%h want=%h", i, op, fa, fb, obs() & e.m, e.v & e.m);
            end else $display("txn b2b_%0d op%0d ok %h", i, op, obs());
            last = res;
        end
    endtask

    initial begin
        bus.flush_EX        = 1'b0;
        bus.writeData_MEMWB = 32'd0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000, FWD_IDEX, FWD_IDEX);
        step(); step();
        rst_n = 1'b1;
        test_reset();
        test_forward();
        test_alu();
        test_multu();
        test_flush();
        test_store();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
